rst_seq_ctrl: RTL and testbench

Parametrised reset sequencer for the multi-clock system, one instance per clock domain. It takes the domain's synchronised reset and stretches it to a minimum length. It then releases NUM_CH downstream reset lines one after another at a fixed spacing. After start-up it accepts per-channel software reset requests, synchronises them, and applies a stretched reset to the requested channels only.

---
 rtl/rst_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Per-domain reset sequencer: stretches the incoming reset, releases NUM_CH
// channel resets at a fixed spacing, then serves per-channel software resets.
module rst_seq_ctrl #(
  parameter int NUM_CH  = 3,
  parameter int STRETCH = 4,
  parameter int GAP     = 2,
  parameter int NO_STG  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int MAX_LEN = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
  localparam logic [IW-1:0] LAST_CH      = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     stretch_cnt, stretch_nxt;
  logic [CW-1:0]     gap_cnt, gap_nxt;
  logic [IW-1:0]     rel_idx, rel_nxt;
  logic [CW-1:0]     soft_cnt     [NUM_CH];
  logic [CW-1:0]     soft_nxt     [NUM_CH];
  logic [NUM_CH-1:0] sync_rst_nxt;
  logic              rst_done_nxt;

  logic [NUM_CH-1:0] sync_q [NO_STG];
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] detect;

  // Request synchroniser plus edge-detect flop. These run in every state so
  // that a level held through reset is absorbed before RUN is reached.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: every synchroniser stage is cleared explicitly; a stale 0->1
      // history surviving reset would fire a spurious soft reset later.
      for (int s = 0; s < NO_STG; s++) sync_q[s] <= '0;
      edge_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, giving a true shift chain regardless of order.
      sync_q[0] <= SW_RST_REQ;
      for (int s = 1; s < NO_STG; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_q[NO_STG-1];
    end
  end

  assign detect = sync_q[NO_STG-1] & ~edge_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ASSERT;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
      rel_idx     <= '0;
      for (int i = 0; i < NUM_CH; i++) soft_cnt[i] <= '0;
      SYNC_RST    <= '0;
      RST_DONE    <= 1'b0;
    end else begin
      state       <= state_nxt;
      stretch_cnt <= stretch_nxt;
      gap_cnt     <= gap_nxt;
      rel_idx     <= rel_nxt;
      for (int i = 0; i < NUM_CH; i++) soft_cnt[i] <= soft_nxt[i];
      SYNC_RST    <= sync_rst_nxt;
      RST_DONE    <= rst_done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    state_nxt    = state;
    stretch_nxt  = stretch_cnt;
    gap_nxt      = gap_cnt;
    rel_nxt      = rel_idx;
    sync_rst_nxt = SYNC_RST;
    for (int i = 0; i < NUM_CH; i++) soft_nxt[i] = soft_cnt[i];

    case (state)
      ASSERT: begin
        if (stretch_cnt == STRETCH_LAST) begin
          stretch_nxt     = '0;
          gap_nxt         = '0;
          rel_nxt         = '0;
          sync_rst_nxt[0] = 1'b1;
          state_nxt       = (NUM_CH == 1) ? RUN : RELEASE;
        end else begin
          stretch_nxt = stretch_cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt = '0;
          rel_nxt = rel_idx + 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            if (IW'(i) == rel_nxt) sync_rst_nxt[i] = 1'b1;
          end
          if (rel_nxt == LAST_CH) state_nxt = RUN;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end

      RUN: begin
        // A fresh edge reloads the counter, so a retrigger extends the reset
        // without the output ever returning high in between.
        for (int i = 0; i < NUM_CH; i++) begin
          if (detect[i]) begin
            soft_nxt[i] = STRETCH_LOAD;
          end else if (soft_cnt[i] != '0) begin
            soft_nxt[i] = soft_cnt[i] - 1'b1;
          end
          sync_rst_nxt[i] = (soft_nxt[i] == '0);
        end
      end

      default: begin
        state_nxt    = ASSERT;
        sync_rst_nxt = '0;
      end
    endcase

    rst_done_nxt = (state_nxt == RUN);
    for (int i = 0; i < NUM_CH; i++) begin
      if (soft_nxt[i] != '0) rst_done_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NUM_CH=3, STRETCH=4, GAP=2, NO_STG=2.
module tb_rst_seq_ctrl;

  logic       CLK;
  logic       RST;
  logic [2:0] SW_RST_REQ;
  logic [2:0] SYNC_RST;
  logic       RST_DONE;

  int total = 0;
  int bad   = 0;

  rst_seq_ctrl #(
    .NUM_CH (3),
    .STRETCH(4),
    .GAP    (2),
    .NO_STG (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_RST_REQ(SW_RST_REQ),
    .SYNC_RST  (SYNC_RST),
    .RST_DONE  (RST_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected power-up outputs after edge e (edge 1 = first edge with RST high).
  function automatic logic [2:0] exp_seq(input int e);
    return {e >= 8, e >= 6, e >= 4};
  endfunction

  task automatic bring_up();
    SW_RST_REQ = 3'b000;
    RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    SW_RST_REQ = 3'b000;
    RST = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      step();
      total++;
      if (SYNC_RST !== 3'b000 || RST_DONE !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold r=%0d SYNC_RST=%b RST_DONE=%b expected 000/0", r, SYNC_RST, RST_DONE);
      end
    end
    RST = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      total++;
      if (SYNC_RST !== exp_seq(e) || RST_DONE !== (e >= 8)) begin
        bad++;
        $display("FAIL powerup e=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 e, SYNC_RST, RST_DONE, exp_seq(e), (e >= 8));
      end
    end
  endtask

  task automatic test_single();
    logic       active;
    logic [2:0] exp;
    bring_up();
    SW_RST_REQ = 3'b010;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 0) SW_RST_REQ = 3'b000;
      active = (k >= 2 && k <= 5);
      exp = active ? 3'b101 : 3'b111;
      total++;
      if (SYNC_RST !== exp || RST_DONE !== !active) begin
        bad++;
        $display("FAIL single k=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 k, SYNC_RST, RST_DONE, exp, !active);
      end
    end
  endtask

  task automatic test_retrigger();
    logic       active;
    logic [2:0] exp;
    bring_up();
    for (int k = 0; k <= 10; k++) begin
      SW_RST_REQ = (k == 0 || k == 3) ? 3'b010 : 3'b000;
      step();
      active = (k >= 2 && k <= 8);
      exp = active ? 3'b101 : 3'b111;
      total++;
      if (SYNC_RST !== exp || RST_DONE !== !active) begin
        bad++;
        $display("FAIL retrigger k=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 k, SYNC_RST, RST_DONE, exp, !active);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic       active;
    logic [2:0] exp;
    bring_up();
    for (int k = 0; k <= 7; k++) begin
      SW_RST_REQ = (k == 0) ? 3'b111 : 3'b000;
      step();
      active = (k >= 2 && k <= 5);
      exp = active ? 3'b000 : 3'b111;
      total++;
      if (SYNC_RST !== exp || RST_DONE !== !active) begin
        bad++;
        $display("FAIL simultaneous k=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 k, SYNC_RST, RST_DONE, exp, !active);
      end
    end
  endtask

  task automatic test_reset_mid();
    SW_RST_REQ = 3'b000;
    RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      total++;
      if (SYNC_RST !== exp_seq(e)) begin
        bad++;
        $display("FAIL mid_pre e=%0d SYNC_RST=%b expected %b", e, SYNC_RST, exp_seq(e));
      end
    end
    RST = 1'b0;
    step();
    total++;
    if (SYNC_RST !== 3'b000 || RST_DONE !== 1'b0) begin
      bad++;
      $display("FAIL mid_release_reset SYNC_RST=%b RST_DONE=%b expected 000/0", SYNC_RST, RST_DONE);
    end
    RST = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++;
      if (SYNC_RST !== exp_seq(e) || RST_DONE !== (e >= 8)) begin
        bad++;
        $display("FAIL mid_restart e=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 e, SYNC_RST, RST_DONE, exp_seq(e), (e >= 8));
      end
    end
    // Reset arriving in the middle of a soft reset on channel 0.
    SW_RST_REQ = 3'b001;
    step();
    SW_RST_REQ = 3'b000;
    repeat (3) step();
    total++;
    if (SYNC_RST !== 3'b110 || RST_DONE !== 1'b0) begin
      bad++;
      $display("FAIL mid_soft_active SYNC_RST=%b RST_DONE=%b expected 110/0", SYNC_RST, RST_DONE);
    end
    RST = 1'b0;
    step();
    total++;
    if (SYNC_RST !== 3'b000 || RST_DONE !== 1'b0) begin
      bad++;
      $display("FAIL mid_soft_reset SYNC_RST=%b RST_DONE=%b expected 000/0", SYNC_RST, RST_DONE);
    end
    RST = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      total++;
      if (SYNC_RST !== exp_seq(e) || RST_DONE !== (e >= 8)) begin
        bad++;
        $display("FAIL mid_soft_restart e=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 e, SYNC_RST, RST_DONE, exp_seq(e), (e >= 8));
      end
    end
  endtask

  task automatic test_ignored();
    SW_RST_REQ = 3'b001;
    RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      SW_RST_REQ = {e == 2, 1'b0, 1'b1};
      step();
      total++;
      if (SYNC_RST !== exp_seq(e) || RST_DONE !== (e >= 8)) begin
        bad++;
        $display("FAIL ignored e=%0d SYNC_RST=%b RST_DONE=%b expected %b/%b",
                 e, SYNC_RST, RST_DONE, exp_seq(e), (e >= 8));
      end
    end
    SW_RST_REQ = 3'b000;
    for (int k = 0; k < 6; k++) begin
      step();
      total++;
      if (SYNC_RST !== 3'b111 || RST_DONE !== 1'b1) begin
        bad++;
        $display("FAIL ignored_fall k=%0d SYNC_RST=%b RST_DONE=%b expected 111/1",
                 k, SYNC_RST, RST_DONE);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    SW_RST_REQ = 3'b000;
    test_reset();
    test_single();
    test_retrigger();
    test_simultaneous();
    test_reset_mid();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
